descriptor_ram_dp: RTL
======================

DESCRIPTOR_RAM_DP -- requirements
Module: descriptor_ram_dp

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, word address width; DEPTH = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter READ_LATENCY, default 1, legal 1 or 2, cycles from accepted read to readdatavalid.
REQ-004 SHALL have parameter CLEAR_ON_RESET, default 1; 1 = zero-fill all words after reset.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 sN_address  in  ADDR_WIDTH  word address, port N in {1,2}.
REQ-008 sN_byteenable  in  DATA_WIDTH/8  per-byte write enable.
REQ-009 sN_chipselect, sN_read, sN_write  in  1 each  Avalon-MM command qualifiers.
REQ-010 sN_writedata  in  DATA_WIDTH  write data.
REQ-011 sN_waitrequest  out  1  command not accepted this cycle.
REQ-012 sN_readdata  out  DATA_WIDTH  read data, valid only with readdatavalid.
REQ-013 sN_readdatavalid  out  1  one-cycle pulse per accepted read.
REQ-014 clear_busy  out  1  high while zero-fill is running.

Function
REQ-015 Command accepted on port N SHALL mean chipselect & (read | write) & !waitrequest; read & write together SHALL be treated as a write only.
REQ-016 Control FSM SHALL have states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-017 In CLEAR a counter SHALL write zero to address 0..DEPTH-1, one word per cycle, then go to READY after the DEPTH-1 write (DEPTH cycles total).
REQ-018 sN_waitrequest and clear_busy SHALL be 1 in CLEAR and 0 in READY; no other stall source exists.
REQ-019 Accepted write SHALL update only bytes with byteenable=1; byteenable=0 SHALL be a no-op write.
REQ-020 Accepted read SHALL assert sN_readdatavalid exactly READ_LATENCY cycles later with the addressed word; reads SHALL be fully pipelined (one per cycle per port).
REQ-021 Same-port write then read of same address on next cycle SHALL return the new data.
REQ-022 Port 2 reading an address port 1 writes in the same cycle (and vice versa) SHALL return the old data.
REQ-023 Both ports writing the same address in the same cycle: port 1 bytes SHALL win wherever both byteenables are set; other bytes take whichever port enabled them.
REQ-024 Address arithmetic SHALL be unsigned ADDR_WIDTH; clear counter SHALL not wrap past DEPTH-1.

Reset
REQ-025 Reset SHALL force readdatavalid=0 on both ports next cycle, discard all in-flight reads, and zero the read pipeline registers.
REQ-026 Reset asserted during CLEAR or READY SHALL restart the clear counter at 0 (CLEAR_ON_RESET=1).
REQ-027 Memory contents SHALL be retained across reset when CLEAR_ON_RESET=0.
REQ-028 sN_readdata SHALL be 0 after reset until the first readdatavalid.

Structure
REQ-029 Shared package SHALL hold the FSM state type and the legal-READ_LATENCY constants.
REQ-030 One sub-module, descriptor_ram_dp_bank, SHALL hold the true-dual-port byte-enabled storage array; collision, clear and latency logic stay in the top level.

Verification
REQ-031 Reset, CLEAR_ON_RESET=1, DEPTH=1024 -> waitrequest/clear_busy high exactly 1024 cycles; subsequent read of 0x3FF returns 0.
REQ-032 s1 write 0x3FF=0xDEADBEEF, be=4'b0101, over 0 -> read returns 0x00AD00EF after READ_LATENCY cycles.
REQ-033 Back-to-back s1 reads addr 0..7 every cycle, READ_LATENCY=2 -> eight consecutive readdatavalid pulses, in order, first two cycles after first read.
REQ-034 Same cycle s1 write 0x10=0x11111111 be=4'hF, s2 write 0x10=0x22222222 be=4'hC -> later read 0x10 = 0x11111111; s2 read 0x20 during s1 write 0x20 returns old value.
REQ-035 Reset pulsed with three reads in flight -> no readdatavalid afterward; clear restarts from address 0.

Source files
------------

// File: rtl/descriptor_ram_dp_pkg.sv
// Shared definitions for the dual-port descriptor RAM: control FSM encoding
// and the supported read-latency settings.
package descriptor_ram_dp_pkg;

  // Control FSM state type with legacy-compatible constant encodings.
  typedef logic [0:0] state_t;
  localparam state_t ST_CLEAR = 1'b0;
  localparam state_t ST_READY = 1'b1;

  // Supported READ_LATENCY values.
  localparam int unsigned READ_LATENCY_MIN = 1;
  localparam int unsigned READ_LATENCY_MAX = 2;

  // Selects the two-stage read pipeline. Any value other than the maximum
  // falls back to the single-stage pipeline.
  function automatic bit latency_is_two(input int unsigned lat);
    return lat == READ_LATENCY_MAX;
  endfunction

endpackage

// File: rtl/descriptor_ram_dp_bank.sv
// True-dual-port, byte-enabled storage array with registered read-before-write
// outputs. Port a has priority over port b on bytes both ports write to the
// same word in the same cycle.
module descriptor_ram_dp_bank
  import descriptor_ram_dp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   a_addr,
  input  logic [DATA_WIDTH/8-1:0] a_be,
  input  logic [DATA_WIDTH-1:0]   a_wdata,
  input  logic                    a_we,
  input  logic                    a_re,
  output logic [DATA_WIDTH-1:0]   a_rdata,
  input  logic [ADDR_WIDTH-1:0]   b_addr,
  input  logic [DATA_WIDTH/8-1:0] b_be,
  input  logic [DATA_WIDTH-1:0]   b_wdata,
  input  logic                    b_we,
  input  logic                    b_re,
  output logic [DATA_WIDTH-1:0]   b_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Byte-wise writes; port a is applied last so it wins on shared bytes.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (b_we && b_be[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      if (a_we && a_be[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
    end
  end

  // Registered reads return the word as it was before this cycle's writes;
  // the output only changes on an accepted read and is zeroed by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      if (a_re) a_rdata <= mem[a_addr];
      if (b_re) b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/descriptor_ram_dp.sv
// Dual-port Avalon-MM descriptor RAM with optional zero-fill after reset and
// a configurable 1- or 2-cycle read pipeline.
module descriptor_ram_dp
  import descriptor_ram_dp_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic                    s2_waitrequest,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    clear_busy
);

  localparam bit LAT2 = latency_is_two(READ_LATENCY);

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_addr;
  logic                    ready;

  logic                    s1_acc, s1_wr_acc, s1_rd_acc;
  logic                    s2_acc, s2_wr_acc, s2_rd_acc;

  logic [ADDR_WIDTH-1:0]   a_addr;
  logic [DATA_WIDTH/8-1:0] a_be;
  logic [DATA_WIDTH-1:0]   a_wdata;
  logic                    a_we;

  logic [DATA_WIDTH-1:0]   s1_q, s2_q;
  logic                    s1_v1, s2_v1;

  assign ready          = (state == ST_READY);
  assign s1_waitrequest = !ready;
  assign s2_waitrequest = !ready;
  assign clear_busy     = !ready;

  // Command acceptance; read+write together is a write. Commands presented
  // in a reset cycle are dropped so reset fully dominates.
  always_comb begin
    s1_acc    = s1_chipselect && (s1_read || s1_write) && ready && !reset;
    s1_wr_acc = s1_acc && s1_write;
    s1_rd_acc = s1_acc && !s1_write;
    s2_acc    = s2_chipselect && (s2_read || s2_write) && ready && !reset;
    s2_wr_acc = s2_acc && s2_write;
    s2_rd_acc = s2_acc && !s2_write;
  end

  // Port a of the bank carries s1 traffic in READY and the zero-fill in
  // CLEAR; both host ports are stalled during CLEAR so nothing competes.
  always_comb begin
    a_addr  = s1_address;
    a_be    = s1_byteenable;
    a_wdata = s1_writedata;
    a_we    = s1_wr_acc;
    if (!ready) begin
      a_addr  = clr_addr;
      a_be    = '1;
      a_wdata = '0;
      a_we    = 1'b1;
    end
  end

  // Control FSM: zero-fill one word per cycle, stop after the last address.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      clr_addr <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_addr == '1) state    <= ST_READY;
      else                clr_addr <= clr_addr + 1'b1;
    end
  end

  // First read-pipeline stage valid flags, aligned with the bank outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v1 <= 1'b0;
      s2_v1 <= 1'b0;
    end else begin
      s1_v1 <= s1_rd_acc;
      s2_v1 <= s2_rd_acc;
    end
  end

  descriptor_ram_dp_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .a_addr  (a_addr),
    .a_be    (a_be),
    .a_wdata (a_wdata),
    .a_we    (a_we),
    .a_re    (s1_rd_acc),
    .a_rdata (s1_q),
    .b_addr  (s2_address),
    .b_be    (s2_byteenable),
    .b_wdata (s2_writedata),
    .b_we    (s2_wr_acc),
    .b_re    (s2_rd_acc),
    .b_rdata (s2_q)
  );

  if (LAT2) begin : g_lat2
    logic [DATA_WIDTH-1:0] s1_d2, s2_d2;
    logic                  s1_v2, s2_v2;

    // Second pipeline stage: hold data until the next valid read emerges.
    always_ff @(posedge clk) begin
      if (reset) begin
        s1_d2 <= '0;
        s2_d2 <= '0;
        s1_v2 <= 1'b0;
        s2_v2 <= 1'b0;
      end else begin
        s1_v2 <= s1_v1;
        s2_v2 <= s2_v1;
        if (s1_v1) s1_d2 <= s1_q;
        if (s2_v1) s2_d2 <= s2_q;
      end
    end

    assign s1_readdata      = s1_d2;
    assign s2_readdata      = s2_d2;
    assign s1_readdatavalid = s1_v2;
    assign s2_readdatavalid = s2_v2;
  end else begin : g_lat1
    assign s1_readdata      = s1_q;
    assign s2_readdata      = s2_q;
    assign s1_readdatavalid = s1_v1;
    assign s2_readdatavalid = s2_v1;
  end

endmodule
